// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC/imem fetch controller with redirect squash and one-entry skid (clk, rst_n, add_out, branch_taken, jump_en, jump_target, stall, imem_req/addr/ack/rdata, inst_valid, inst, pc_out, pc_plus4)
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] add_out,
  input  logic        branch_taken,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT_DRAIN} state_t;
  state_t state;
  logic [31:0] pc, skid_inst, skid_pc, target, pc_next;
  logic squash, redirect, acked, accept;
  always_comb begin
    redirect = jump_en | branch_taken;
    target = (jump_en ? jump_target : add_out) & ~32'd3;
    acked = imem_req & imem_ack;
    accept = ~stall | ~inst_valid;
    pc_next = pc + 32'd4;
  end
  assign pc_plus4 = pc_out + 32'd4;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      inst_valid <= 1'b0;
      inst <= NOP_INST;
      pc_out <= RESET_PC;
      skid_inst <= NOP_INST;
      skid_pc <= RESET_PC;
      squash <= 1'b0;
    end else if (state == IDLE) begin
      state <= FETCH;
      imem_req <= 1'b1;
      imem_addr <= pc;
    end else if (redirect) begin
      state <= FETCH;
      pc <= target;
      inst_valid <= 1'b0;
      inst <= NOP_INST;
      skid_inst <= NOP_INST;
      if (imem_req && !imem_ack) squash <= 1'b1;
      else begin
        squash <= 1'b0;
        imem_req <= 1'b1;
        imem_addr <= target;
      end
    end else if (state == WAIT_DRAIN) begin
      if (!stall) begin
        state <= FETCH;
        inst_valid <= 1'b1;
        inst <= skid_inst;
        pc_out <= skid_pc;
      end
    end else begin
      if (acked && !squash && accept) begin
        inst_valid <= 1'b1;
        inst <= imem_rdata;
        pc_out <= pc;
      end else if (!stall) begin
        inst_valid <= 1'b0;
        inst <= NOP_INST;
      end
      if (acked) begin
        squash <= 1'b0;
        if (squash) imem_addr <= pc;
        else begin
          pc <= pc_next;
          if (accept) imem_addr <= pc_next;
          else begin
            skid_inst <= imem_rdata;
            skid_pc <= pc;
            imem_req <= 1'b0;
            state <= WAIT_DRAIN;
          end
        end
      end else if (!imem_req) begin
        imem_req <= 1'b1;
        imem_addr <= pc;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: randomized and directed checks of pc_fetch_ctrl against an instruction-stream reference model
module tb_pc_fetch_ctrl;
  logic clk = 1'b0, rst_n, branch_taken, jump_en, stall, imem_ack, imem_req, inst_valid;
  logic [31:0] add_out, jump_target, imem_addr, imem_rdata, inst, pc_out, pc_plus4;
  int n_chk = 0, n_fail = 0, lat = 1, cnt = 0, since_rst = 0, delivered = 0;
  bit force_ack = 0, rand_lat = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] fetch_q[$];
  logic [31:0] a;
  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .add_out(add_out), .branch_taken(branch_taken),
    .jump_en(jump_en), .jump_target(jump_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .pc_out(pc_out), .pc_plus4(pc_plus4)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] addr);
    return addr ^ 32'h5a5a_1234;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    logic v, req, ack, redir, hold;
    logic [31:0] po, in, pp4, ad, tgt;
    ack = force_ack ? 1'b1 : (imem_req && cnt >= lat);
    imem_ack = ack;
    imem_rdata = force_ack ? 32'hdead_beef : mem_f(imem_addr);
    v = inst_valid; po = pc_out; in = inst; pp4 = pc_plus4; req = imem_req; ad = imem_addr;
    redir = jump_en | branch_taken;
    tgt = jump_en ? jump_target : add_out;
    @(posedge clk);
    hold = rst_n && req && !ack;
    if (!rst_n) begin
      exp_pc = 32'h0; since_rst = 0; cnt = 0;
    end else begin
      if (req && ack) begin
        fetch_q.push_back(ad);
        cnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else if (req) cnt++;
      if (redir && since_rst > 0) exp_pc = tgt & ~32'd3;
      else if (v && !stall) begin
        chk("pc_out", po, exp_pc);
        chk("inst", in, mem_f(exp_pc));
        chk("pc_plus4", pp4, exp_pc + 32'd4);
        exp_pc += 32'd4;
        delivered++;
      end
      since_rst++;
    end
    #1;
    if (hold) chk("req_hold", {31'b0, imem_req}, 32'd1);
    if (!inst_valid) chk("nop", inst, 32'h0);
    branch_taken = 1'b0; jump_en = 1'b0; force_ack = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  task automatic redir(input bit j, input logic [31:0] jt, input logic [31:0] bt, output logic [31:0] first);
    int need;
    need = imem_req ? 2 : 1;
    fetch_q.delete();
    jump_en = j; jump_target = jt; branch_taken = 1'b1; add_out = bt;
    step();
    for (int k = 0; k < 60 && fetch_q.size() < need; k++) step();
    first = fetch_q.size() >= need ? fetch_q[need-1] : 32'hxxxx_xxxx;
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
    add_out = 32'h0; jump_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    rst_n = 1'b1;
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    fetch_q.delete();
    for (int k = 0; k < 40 && fetch_q.size() < 4; k++) step();
    chk("seq_len", fetch_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < fetch_q.size(); i++) chk("seq_addr", fetch_q[i], 32'(4 * i));
    do_reset();
    lat = 1;
    for (int k = 0; k < 40 && !(inst_valid && pc_out == 32'h4); k++) step();
    chk("stall_setup", pc_out, 32'h4);
    stall = 1'b1;
    fetch_q.delete();
    for (int k = 0; k < 20 && fetch_q.size() == 0; k++) step();
    chk("stall_ack_addr", fetch_q.size() > 0 ? fetch_q[0] : 32'hx, 32'h8);
    chk("stall_hold_valid", {31'b0, inst_valid}, 32'd1);
    chk("stall_hold_pc", pc_out, 32'h4);
    chk("stall_req_low", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    step();
    chk("drain_pc", pc_out, 32'h8);
    chk("drain_valid", {31'b0, inst_valid}, 32'd1);
    chk("drain_req_low", {31'b0, imem_req}, 32'd0);
    step();
    chk("drain_next_req", {31'b0, imem_req}, 32'd1);
    chk("drain_next_addr", imem_addr, 32'hc);
    do_reset();
    lat = 3;
    for (int k = 0; k < 100 && !(imem_req && imem_addr == 32'h10 && cnt == 0); k++) step();
    chk("br_setup", imem_addr, 32'h10);
    redir(1'b0, 32'h0, 32'h0000_0102, a);
    chk("br_squashed_addr", fetch_q.size() > 0 ? fetch_q[0] : 32'hx, 32'h10);
    chk("br_target_addr", a, 32'h100);
    chk("br_deliver_pc", pc_out, 32'h100);
    redir(1'b1, 32'h200, 32'h300, a);
    chk("jmp_priority", a, 32'h200);
    redir(1'b1, 32'hffff_fffc, 32'h0, a);
    chk("wrap_fetch", a, 32'hffff_fffc);
    for (int k = 0; k < 40 && !(inst_valid && pc_out == 32'hffff_fffc); k++) step();
    chk("wrap_pc_out", pc_out, 32'hffff_fffc);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    fetch_q.delete();
    for (int k = 0; k < 40 && fetch_q.size() == 0; k++) step();
    chk("wrap_next_addr", fetch_q.size() > 0 ? fetch_q[0] : 32'hx, 32'h0);
    do_reset();
    lat = 5;
    for (int k = 0; k < 400 && !(imem_req && imem_addr == 32'h40); k++) step();
    chk("stale_setup", imem_addr, 32'h40);
    do_reset();
    chk("stale_rst_req", {31'b0, imem_req}, 32'd0);
    chk("stale_rst_addr", imem_addr, 32'h0);
    chk("stale_rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("stale_rst_inst", inst, 32'h0);
    chk("stale_rst_pc_out", pc_out, 32'h0);
    force_ack = 1'b1;
    step();
    chk("stale_valid", {31'b0, inst_valid}, 32'd0);
    chk("stale_restart_req", {31'b0, imem_req}, 32'd1);
    chk("stale_restart_addr", imem_addr, 32'h0);
    lat = 1;
    fetch_q.delete();
    for (int k = 0; k < 20 && fetch_q.size() == 0; k++) step();
    chk("stale_first_fetch", fetch_q.size() > 0 ? fetch_q[0] : 32'hx, 32'h0);
    do_reset();
    rand_lat = 1;
    delivered = 0;
    for (int c = 0; c < 5000; c++) begin
      stall = $urandom_range(0, 9) < 3;
      if (since_rst > 0 && $urandom_range(0, 99) < 4) begin
        jump_en = $urandom_range(0, 1);
        branch_taken = !jump_en || $urandom_range(0, 1);
        jump_target = $urandom();
        add_out = $urandom();
      end
      rst_n = $urandom_range(0, 999) >= 3;
      step();
    end
    rst_n = 1'b1;
    chk("progress", {31'b0, delivered > 300}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and instruction-fetch controller in the datapath front end. It holds the PC, issues word fetches to instruction memory over a req/ack handshake, and presents the fetched instruction together with its PC (pc_out) downstream. pc_out is the PC input of the branch-target adder, and that adder's result (add_out) returns here as the taken-branch target. The block also handles jump redirects, pipeline stall with a one-entry skid buffer, and squashing of wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0000, value driven on inst when no valid instruction is held

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
add_out  in  32  branch target from the branch-target adder
branch_taken  in  1  one-cycle pulse: redirect to add_out
jump_en  in  1  one-cycle pulse: redirect to jump_target
jump_target  in  32  jump destination
stall  in  1  downstream cannot accept; hold the output stage
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address
imem_ack  in  1  read complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
inst_valid  out  1  inst/pc_out hold a valid instruction
inst  out  32  fetched instruction
pc_out  out  32  address of inst
pc_plus4  out  32  pc_out + 4, combinational

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; inst_valid=0; inst=NOP_INST; pc_out=RESET_PC.
  - Skid buffer empty; squash flag clear.
  - Reset overrides any in-flight fetch; a later imem_ack for that fetch is ignored.
- First request: imem_req rises in the first cycle after rst_n goes high.
- FSM states: IDLE, FETCH, WAIT_DRAIN.
  - IDLE -> FETCH unconditionally (one cycle after reset release).
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - Once asserted, imem_req and imem_addr stay stable until the imem_ack cycle.
  - At most one fetch is outstanding.
  - imem_req may remain high back-to-back; each ack completes one transaction.
  - The next address appears in the cycle after the ack.
- Ack without squash:
  - If the output stage can accept (stall=0 or inst_valid=0): inst<=imem_rdata, pc_out<=pc, inst_valid<=1.
  - Otherwise the data and its PC go to the skid buffer, and the state becomes WAIT_DRAIN.
  - In both cases pc<=pc+4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
- WAIT_DRAIN:
  - imem_req=0.
  - When stall=0, the buffer moves to the output stage and the state returns to FETCH; the next request is issued the following cycle.
- Output stage while stall=0:
  - inst_valid clears after one cycle unless a new instruction is loaded.
  - On clearing, inst returns to NOP_INST.
- Output stage while stall=1: inst, pc_out and inst_valid hold.
- Redirect (branch_taken or jump_en high at an edge):
  - Priority: jump_en over branch_taken.
  - Target has bits [1:0] forced to 0.
  - pc<=target; inst_valid<=0; inst<=NOP_INST; skid buffer cleared.
  - Redirect applies even when stall=1; the stall is then ignored for the flushed slot.
  - If a fetch is outstanding and not acked this cycle, the squash flag is set; when its ack arrives the data is discarded, pc is not incremented, and the next request uses the target.
  - Redirect in the same cycle as an ack: the acked data is discarded.
  - From WAIT_DRAIN: go to FETCH.
  - A redirect during IDLE is ignored.
- Multiple redirects before the squashed ack: the last target wins.
- pc_plus4 = pc_out + 4, modulo 2^32.

Test Plan:
- Reset, then memory with 1-cycle ack latency, stall=0 -> imem_addr sequence 0,4,8,C; inst_valid pulses with pc_out matching each address; first imem_req in the cycle after rst_n rises.
- stall=1 while inst_valid=1 (pc_out=4), ack for addr 8 arrives -> outputs hold at pc_out=4, imem_req=0. Release stall -> pc_out=8 the next cycle, then request for addr C.
- branch_taken with add_out=32'h0000_0102 while fetch of 0x10 is outstanding with ack 3 cycles later -> data of 0x10 discarded, inst_valid stays 0, next imem_addr=32'h0000_0100.
- jump_en (jump_target=0x200) and branch_taken (add_out=0x300) in the same cycle -> next fetch address 0x200.
- pc=32'hFFFF_FFFC fetch acked -> next imem_addr=0; pc_plus4 for pc_out=32'hFFFF_FFFC is 0.
- rst_n low for one cycle mid-fetch (addr 0x40 outstanding), stale ack arrives after reset -> ignored; outputs equal reset values; fetch restarts at RESET_PC.
